// File: rtl/multicycle_rv_core.sv
// Multicycle reduced RV32I core: FETCH/DECODE/EXEC/WB around one shared ALU, with handshake fetch.
// Optional cycle/instret counters are enabled by defining RV_PERF_CNT_EN.
module multicycle_rv_core #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned NREGS    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_valid,
    input  logic [31:0]         instr_rdata,
    output logic                halted,
    output logic                retire,
    output logic [XLEN-1:0]     a0
`ifdef RV_PERF_CNT_EN
    ,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         instret_cnt
`endif
);

    localparam int unsigned RW = $clog2(NREGS);
    localparam logic [5:0]  NREG6 = 6'(NREGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]          r_state, w_state_nx;
    logic                r_req, r_halted, r_retire, r_take;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir, r_imm;
    logic [XLEN-1:0]     r_a, r_b, r_res;
    logic [XLEN-1:0]     r_regs [NREGS];

    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic        w_is_addi, w_is_rr, w_is_lui, w_is_br, w_writes, w_bad_idx, w_illegal;
    logic [31:0] w_imm;
    logic [XLEN-1:0] w_alu;

    assign w_op  = r_ir[6:0];
    assign w_rd  = r_ir[11:7];
    assign w_f3  = r_ir[14:12];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_f7  = r_ir[31:25];

    assign w_is_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_rr   = (w_op == 7'b0110011) && (w_f3 == 3'b000) &&
                       ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
    assign w_is_lui  = (w_op == 7'b0110111);
    assign w_is_br   = (w_op == 7'b1100011) && ((w_f3 == 3'b000) || (w_f3 == 3'b001));
    assign w_writes  = w_is_addi || w_is_rr || w_is_lui;

    // Only fields the instruction actually uses are range-checked against NREGS.
    assign w_bad_idx = ((w_is_addi || w_is_rr || w_is_br) && ({1'b0, w_rs1} >= NREG6)) ||
                       ((w_is_rr || w_is_br) && ({1'b0, w_rs2} >= NREG6)) ||
                       (w_writes && ({1'b0, w_rd} >= NREG6));
    assign w_illegal = !(w_writes || w_is_br) || w_bad_idx;

    always_comb begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_is_br) begin
            w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        end else if (w_is_lui) begin
            w_imm = {r_ir[31:12], 12'b0};
        end
    end

    always_comb begin
        w_alu = r_a + XLEN'($signed(r_imm));
        if (w_is_rr) begin
            w_alu = r_ir[30] ? (r_a - r_b) : (r_a + r_b);
        end else if (w_is_lui) begin
            w_alu = XLEN'($signed(r_imm));
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_FETCH:  if (r_req && instr_valid) w_state_nx = S_DECODE;
            S_DECODE: w_state_nx = w_illegal ? S_HALT : S_EXEC;
            S_EXEC:   w_state_nx = S_WB;
            S_WB:     w_state_nx = S_FETCH;
            S_HALT:   w_state_nx = S_HALT;
            default:  w_state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_state_nx;
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req    <= 1'b0;
            r_retire <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_req    <= (w_state_nx == S_FETCH);
            r_retire <= (w_state_nx == S_WB);
            r_halted <= r_halted || (w_state_nx == S_HALT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_ir   <= '0;
            r_imm  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_take <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (r_req && instr_valid) r_ir <= instr_rdata;
                S_DECODE: begin
                    r_a   <= r_regs[w_rs1[RW-1:0]];
                    r_b   <= r_regs[w_rs2[RW-1:0]];
                    r_imm <= w_imm;
                end
                S_EXEC: begin
                    r_res  <= w_alu;
                    r_take <= w_is_br && ((r_a == r_b) != w_f3[0]);
                end
                S_WB: begin
                    if (w_writes && (w_rd != 5'd0)) r_regs[w_rd[RW-1:0]] <= r_res;
                    r_pc <= r_take ? (r_pc + PC_WIDTH'($signed(r_imm))) : (r_pc + PC_WIDTH'(4));
                end
                default: ;
            endcase
        end
    end

    assign instr_req  = r_req;
    assign instr_addr = r_pc;
    assign halted     = r_halted;
    assign retire     = r_retire;
    assign a0         = r_regs[10];

`ifdef RV_PERF_CNT_EN
    logic [63:0] r_cycle, r_instret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else if (!r_halted) begin
            r_cycle <= r_cycle + 64'd1;
            if (r_retire) r_instret <= r_instret + 64'd1;
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_rv_core.sv
// Directed bench for multicycle_rv_core: a small ISA model pushes expected a0/next-PC per instruction,
// popped and compared when the core retires.
module tb_multicycle_rv_core;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 32;

    localparam int K_ADDI = 0;
    localparam int K_ADD  = 1;
    localparam int K_SUB  = 2;
    localparam int K_LUI  = 3;
    localparam int K_BEQ  = 4;
    localparam int K_BNE  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_req;
    logic [PCW-1:0]  instr_addr;
    logic            instr_valid;
    logic [31:0]     instr_rdata;
    logic            halted;
    logic            retire;
    logic [XLEN-1:0] a0;
`ifdef RV_PERF_CNT_EN
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;
`endif

    multicycle_rv_core #(
        .XLEN(XLEN), .PC_WIDTH(PCW), .NREGS(32), .RESET_PC(32'h100)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_rdata(instr_rdata),
        .halted(halted), .retire(retire), .a0(a0)
`ifdef RV_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_ret = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = 32'h100;
        sb_q.delete();
    endtask

    function automatic logic [31:0] encode(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        case (kind)
            K_ADDI:  w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            K_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_LUI:   w = {imm[19:0], rd, 7'b0110111};
            K_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            default: w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
        endcase
        return w;
    endfunction

    // Present one instruction word to the core, checking the request side of the handshake.
    task automatic do_fetch(input logic [31:0] word, input int waits, input string tag);
        int n = 0;
        while (instr_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 64'(instr_req), 64'd1);
        check({tag, "_addr"}, 64'(instr_addr), 64'(m_pc));
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, "_req_held"}, 64'(instr_req), 64'd1);
            check({tag, "_addr_held"}, 64'(instr_addr), 64'(m_pc));
        end
        instr_rdata = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr_rdata = $urandom;
        check({tag, "_req_drop"}, 64'(instr_req), 64'd0);
    endtask

    task automatic wait_retire(input int gap, input string tag);
        int n = 0;
        exp_t e;
        while (retire !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_retire"}, 64'(retire), 64'd1);
        if (gap != 0) check({tag, "_gap"}, 64'(cyc - last_ret), 64'(gap));
        last_ret = cyc;
        tick();
        check({tag, "_retire_pulse"}, 64'(retire), 64'd0);
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: observed empty scoreboard, expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_a0"}, 64'(a0), 64'(e.a0));
            check({tag, "_next_pc"}, 64'(instr_addr), 64'(e.pc));
        end
    endtask

    task automatic issue(input int kind, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input int waits, input int gap, input string tag);
        logic [31:0] r1, r2, res, npc;
        exp_t e;
        do_fetch(encode(kind, rd, rs1, rs2, imm), waits, tag);
        r1  = m_regs[rs1];
        r2  = m_regs[rs2];
        npc = m_pc + 32'd4;
        res = '0;
        case (kind)
            K_ADDI: res = r1 + imm;
            K_ADD:  res = r1 + r2;
            K_SUB:  res = r1 - r2;
            K_LUI:  res = imm << 12;
            K_BEQ:  if (r1 == r2) npc = m_pc + imm;
            default: if (r1 != r2) npc = m_pc + imm;
        endcase
        if (kind <= K_LUI && rd != 5'd0) m_regs[rd] = res;
        m_pc = npc;
        e.a0 = m_regs[10];
        e.pc = npc;
        sb_q.push_back(e);
        wait_retire(gap, tag);
    endtask

    // Release reset while a stray valid is on the bus; it must not be taken as a fetch.
    task automatic release_reset(input string tag);
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr_rdata = 32'hFFFF_FFFF;
        tick();
        instr_valid = 1'b0;
        check({tag, "_first_req"}, 64'(instr_req), 64'd1);
        check({tag, "_first_addr"}, 64'(instr_addr), 64'h100);
    endtask

    initial begin
        logic [31:0] a0_hold;
`ifdef RV_PERF_CNT_EN
        logic [63:0] cyc_hold, ret_hold;
`endif
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr_rdata = '0;
        model_reset();
        repeat (2) tick();
        check("rst_req", 64'(instr_req), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_a0", 64'(a0), 64'd0);
        check("rst_addr", 64'(instr_addr), 64'h100);
        release_reset("rel1");

        issue(K_ADDI, 10, 0, 0, 32'd5, 0, 0, "addi5");
        issue(K_ADDI, 10, 10, 0, -32'sd7, 0, 4, "addi_m7");
        issue(K_ADDI, 1, 0, 0, 32'd3, 3, 7, "addi_wait3");
        issue(K_ADDI, 2, 0, 0, 32'd3, 0, 4, "addi_x2");
        issue(K_BEQ, 0, 1, 2, 32'd8, 0, 4, "beq_taken");
        issue(K_BNE, 0, 1, 2, 32'd8, 0, 4, "bne_not");
        issue(K_LUI, 10, 0, 0, 32'h12345, 0, 4, "lui");
        issue(K_ADDI, 0, 0, 0, 32'd9, 0, 4, "x0_write");
        issue(K_ADD, 10, 0, 0, 32'd0, 0, 4, "x0_read");
        issue(K_SUB, 10, 0, 1, 32'd0, 1, 5, "sub");
        issue(K_ADD, 10, 1, 2, 32'd0, 0, 4, "add");
        issue(K_BNE, 0, 1, 0, -32'sd8, 0, 4, "bne_back");
        issue(K_ADDI, 10, 10, 0, -32'sd2048, 0, 4, "addi_min");

        // Core is now in FETCH with the request up; reset must drop it without a clock edge.
        rst = 1'b0;
        #1;
        check("mid_rst_req", 64'(instr_req), 64'd0);
        check("mid_rst_a0", 64'(a0), 64'd0);
        model_reset();
        tick();
        release_reset("rel2");
        issue(K_ADDI, 10, 0, 0, 32'd1, 0, 0, "p1");
        issue(K_ADDI, 10, 10, 0, 32'd1, 0, 4, "p2");
        issue(K_ADDI, 10, 10, 0, 32'd1, 0, 4, "p3");
`ifdef RV_PERF_CNT_EN
        check("instret_3", instret_cnt, 64'd3);
        check("cycle_12pm1", 64'((cycle_cnt >= 64'd11) && (cycle_cnt <= 64'd13)), 64'd1);
`endif

        a0_hold = m_regs[10];
        do_fetch(32'hFFFF_FFFF, 0, "illegal");
        tick();
        check("halt_set", 64'(halted), 64'd1);
        check("halt_req", 64'(instr_req), 64'd0);
`ifdef RV_PERF_CNT_EN
        cyc_hold = cycle_cnt;
        ret_hold = instret_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1;
            tick();
            check("halt_no_retire", 64'(retire), 64'd0);
            check("halt_req_low", 64'(instr_req), 64'd0);
            check("halt_a0", 64'(a0), 64'(a0_hold));
        end
        instr_valid = 1'b0;
`ifdef RV_PERF_CNT_EN
        check("halt_cycle_frozen", cycle_cnt, cyc_hold);
        check("halt_instret_frozen", instret_cnt, ret_hold);
`endif
        rst = 1'b0;
        #1;
        check("halt_cleared", 64'(halted), 64'd0);
        check("halt_rst_a0", 64'(a0), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
